ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one 8-bit command byte from the FPGA to the keyboard, for example 0xED (set LEDs) or 0xF4 (enable). It sits beside the PS/2 receiver on the same CLOCK_50 domain and the same PS2_CLK/PS2_DAT pins. It performs the host request-to-send sequence, shifts data, odd parity and stop bit on device clock edges, checks the device ACK, and reports success or timeout.

## Interface
Parameters:
- INHIBIT_CYCLES, default 5000: clock-low hold time in CLOCK_50 cycles (100 us at 50 MHz).
- TIMEOUT_CYCLES, default 750000: maximum CLOCK_50 cycles between device clock falling edges (15 ms).

Ports:
- CLOCK_50  in  1: system clock; all logic on its rising edge.
- reset  in  1: asynchronous, active-high; clears all state immediately.
- PS2_CLK  in  1: sampled PS/2 clock line.
- PS2_DAT  in  1: sampled PS/2 data line.
- command  in  8: byte to send; latched when accepted.
- send_command  in  1: request strobe; only accepted in IDLE.
- busy  out  1: high from acceptance until done or error.
- command_was_sent  out  1: one-cycle pulse on successful ACK and line release.
- error_communication_timed_out  out  1: one-cycle pulse on timeout or missing ACK.
- PS2_CLK_OUT  out  1: 1 = drive clock line low; 0 = release (open-drain).
- PS2_DAT_OUT  out  1: 1 = drive data line low; 0 = release.

## Operation
- PS2_CLK and PS2_DAT each pass through a 2-flop synchronizer. A falling edge (fe) is a 1→0 transition of the synchronized clock, detected with one extra register.
- Frame word: {parity, command}, where parity = ~^command (odd parity over the 9 bits).
- States:
  - IDLE: both lines released. On send_command=1, latch command, clear counters, go to INHIBIT.
  - INHIBIT: PS2_CLK_OUT=1, PS2_DAT_OUT=0. After INHIBIT_CYCLES cycles, go to RTS.
  - RTS: PS2_CLK_OUT=0, PS2_DAT_OUT=1 (start bit). Wait for fe, then go to DATA with bit index 0.
  - DATA: on each fe, present bit[idx] with PS2_DAT_OUT = ~bit. The order is d0..d7, then parity, at idx 0..8. On the fe after parity, release data (stop bit = 1) and go to WAIT_ACK.
  - WAIT_ACK: on the next fe, sample synchronized PS2_DAT. If 0, go to WAIT_RELEASE. If 1, go to ERROR.
  - WAIT_RELEASE: wait until both synchronized lines are 1, then go to DONE.
  - DONE: pulse command_was_sent, go to IDLE.
  - ERROR: pulse error_communication_timed_out, release both lines, go to IDLE.
- Timeout counter:
  - Cleared on entry to RTS and on every fe.
  - In RTS, DATA, WAIT_ACK or WAIT_RELEASE, reaching TIMEOUT_CYCLES sends the FSM to ERROR.
- busy = (state != IDLE).
- send_command while busy is ignored, not queued. The latched command is unaffected by later changes on the command port.

## Timing
- Reset values:
  - state IDLE.
  - PS2_CLK_OUT=0, PS2_DAT_OUT=0.
  - busy=0, command_was_sent=0, error_communication_timed_out=0.
  - All counters 0.
- Reset asserted mid-frame releases both lines in the same instant (asynchronous). No done or error pulse is issued.
- send_command high at cycle T (in IDLE): at T+1, busy=1 and PS2_CLK_OUT=1.
- PS2_CLK_OUT stays 1 for exactly INHIBIT_CYCLES cycles. In the following cycle, PS2_CLK_OUT=0 and PS2_DAT_OUT=1 switch together.
- Data-line update latency: 3 CLOCK_50 cycles after the pin's falling edge (2 synchronizer stages plus edge register). This is well inside the device's ≥30 us clock-low half-period.
- Device clock falling edges per frame:
  - Edge 1 (after RTS) presents d0.
  - Edges 2–8 present d1..d7.
  - Edge 9 presents parity.
  - Edge 10 releases data (stop).
  - Edge 11 samples ACK.
- command_was_sent pulses exactly 1 cycle, 2 cycles after both lines are seen high. busy drops in the same cycle the pulse ends (state back to IDLE).
- A send_command arriving in the DONE or ERROR cycle is ignored. A new request is accepted from the first IDLE cycle.

## Test plan
(Bench uses INHIBIT_CYCLES=8, TIMEOUT_CYCLES=400; the device model toggles PS2_CLK every 100 cycles.)
- Send 0xED:
  - Stimulus: after the 8-cycle inhibit, the device clocks.
  - Required: the bits driven on the data line are 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - The device ACKs with 0 → command_was_sent pulses once, busy falls, no error.
- Send 0xF4:
  - Required data bits 0,0,1,0,1,1,1,1 and parity 0.
  - ACK → success pulse.
  - Check PS2_CLK_OUT is high for exactly 8 cycles before RTS.
- No ACK:
  - Send 0x55; the device leaves data high on edge 11.
  - Required: error_communication_timed_out pulses once, no success pulse, both lines released.
- Device never clocks:
  - Send 0xFF with PS2_CLK held high.
  - Required: error pulse exactly 400 cycles after RTS entry, then IDLE.
- Busy/reset:
  - Pulse send_command with 0x12 mid-frame of an 0xED send → ignored; the 0xED frame is unchanged.
  - Assert reset at edge 5 → PS2_CLK_OUT=0, PS2_DAT_OUT=0 and busy=0 immediately.
  - A next send of 0xF4 after reset completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte (d0 first, then odd
// parity, then stop) to the attached device. It performs the request-to-send
// sequence, checks the device ACK, and reports success or timeout.
//
// Parameters
//   INHIBIT_CYCLES : CLOCK_50 cycles the clock line is held low before RTS
//   TIMEOUT_CYCLES : max CLOCK_50 cycles between device clock falling edges
//
// Ports
//   CLOCK_50                      in  system clock, rising edge
//   reset                         in  asynchronous active-high reset
//   PS2_CLK / PS2_DAT             in  raw PS/2 line levels (synchronized here)
//   command[7:0]                  in  byte to send, latched on acceptance
//   send_command                  in  request strobe, honoured only in IDLE
//   busy                          out high while a transfer is in progress
//   command_was_sent              out one-cycle pulse on ACK plus line release
//   error_communication_timed_out out one-cycle pulse on timeout / missing ACK
//   PS2_CLK_OUT / PS2_DAT_OUT     out 1 = pull the line low, 0 = release
// ----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic [7:0] command,
    input  logic       send_command,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out,
    output logic       PS2_CLK_OUT,
    output logic       PS2_DAT_OUT
);

    localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_INHIBIT      = 3'd1,
        ST_RTS          = 3'd2,
        ST_DATA         = 3'd3,
        ST_WAIT_ACK     = 3'd4,
        ST_WAIT_RELEASE = 3'd5,
        ST_DONE         = 3'd6,
        ST_ERROR        = 3'd7
    } state_t;

    // Odd parity over data plus parity bit: parity bit is the XNOR of the data.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    state_t           state_q, state_d;
    logic [8:0]       frame_q, frame_d;
    logic [3:0]       idx_q, idx_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             clk_out_q, clk_out_d;
    logic             dat_out_q, dat_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             clk_meta_q, clk_sync_q, clk_prev_q;
    logic             dat_meta_q, dat_sync_q;
    logic             fe_s;
    logic             tmo_hit_s;

    assign fe_s      = clk_prev_q & ~clk_sync_q;
    assign tmo_hit_s = (tmo_q == TMO_LAST);

    // Two-flop synchronizers for both lines plus the clock edge-detect register.
    // Idle lines are high, so reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= PS2_CLK;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= PS2_DAT;
            dat_sync_q <= dat_meta_q;
        end
    end

    // State, datapath and registered output flops.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            frame_q   <= 9'd0;
            idx_q     <= 4'd0;
            inh_q     <= '0;
            tmo_q     <= '0;
            clk_out_q <= 1'b0;
            dat_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            idx_q     <= idx_d;
            inh_q     <= inh_d;
            tmo_q     <= tmo_d;
            clk_out_q <= clk_out_d;
            dat_out_q <= dat_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic. Outputs are derived from the next state so that the
    // registered pins change in the same cycle the state register does.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        idx_d     = idx_q;
        inh_d     = inh_q;
        tmo_d     = tmo_q;
        dat_out_d = dat_out_q;

        case (state_q)
            ST_IDLE: begin
                dat_out_d = 1'b0;
                if (send_command) begin
                    frame_d = {odd_parity(command), command};
                    idx_d   = 4'd0;
                    inh_d   = '0;
                    tmo_d   = '0;
                    state_d = ST_INHIBIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_INHIBIT: begin
                if (inh_q == INH_LAST) begin
                    state_d   = ST_RTS;
                    tmo_d     = '0;
                    dat_out_d = 1'b1;   // start bit: pull data low
                end else begin
                    inh_d     = inh_q + INH_W'(1);
                    dat_out_d = 1'b0;
                end
            end

            ST_RTS: begin
                if (fe_s) begin
                    state_d   = ST_DATA;
                    idx_d     = 4'd0;
                    tmo_d     = '0;
                    dat_out_d = ~frame_q[0];
                end else if (tmo_hit_s) begin
                    state_d   = ST_ERROR;
                    dat_out_d = 1'b0;
                end else begin
                    tmo_d     = tmo_q + TMO_W'(1);
                end
            end

            ST_DATA: begin
                if (fe_s) begin
                    tmo_d = '0;
                    if (idx_q == 4'd8) begin
                        // Parity already on the line: release data for the stop bit.
                        state_d   = ST_WAIT_ACK;
                        dat_out_d = 1'b0;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        dat_out_d = ~frame_q[idx_q + 4'd1];
                    end
                end else if (tmo_hit_s) begin
                    state_d   = ST_ERROR;
                    dat_out_d = 1'b0;
                end else begin
                    tmo_d     = tmo_q + TMO_W'(1);
                end
            end

            ST_WAIT_ACK: begin
                dat_out_d = 1'b0;
                if (fe_s) begin
                    tmo_d   = '0;
                    state_d = dat_sync_q ? ST_ERROR : ST_WAIT_RELEASE;
                end else if (tmo_hit_s) begin
                    state_d = ST_ERROR;
                end else begin
                    tmo_d   = tmo_q + TMO_W'(1);
                end
            end

            ST_WAIT_RELEASE: begin
                dat_out_d = 1'b0;
                if (clk_sync_q && dat_sync_q) begin
                    state_d = ST_DONE;
                end else if (fe_s) begin
                    tmo_d   = '0;
                end else if (tmo_hit_s) begin
                    state_d = ST_ERROR;
                end else begin
                    tmo_d   = tmo_q + TMO_W'(1);
                end
            end

            ST_DONE: begin
                dat_out_d = 1'b0;
                state_d   = ST_IDLE;
            end

            ST_ERROR: begin
                dat_out_d = 1'b0;
                state_d   = ST_IDLE;
            end

            default: begin
                dat_out_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Registered output decode from the next state.
    always_comb begin
        clk_out_d = (state_d == ST_INHIBIT);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        err_d     = (state_d == ST_ERROR);
    end

    assign busy                          = busy_q;
    assign command_was_sent              = done_q;
    assign error_communication_timed_out = err_q;
    assign PS2_CLK_OUT                   = clk_out_q;
    assign PS2_DAT_OUT                   = dat_out_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with a small PS/2 device model. The bus is
// modelled as wired-AND: each line is low if either side pulls it low.
// ----------------------------------------------------------------------------
module tb_ps2_host_tx;

    logic       clk;
    logic       reset;
    logic [7:0] command;
    logic       send_command;
    logic       busy;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic       PS2_CLK_OUT;
    logic       PS2_DAT_OUT;

    logic       dev_clk;
    logic       dev_dat;
    logic       ps2_clk_w;
    logic       ps2_dat_w;

    int vec_cnt;
    int miscompare_cnt;
    int cyc;
    int done_seen;
    int err_seen;
    int err_cyc;
    int rts_cyc;

    assign ps2_clk_w = dev_clk & ~PS2_CLK_OUT;
    assign ps2_dat_w = dev_dat & ~PS2_DAT_OUT;

    ps2_host_tx #(
        .INHIBIT_CYCLES(8),
        .TIMEOUT_CYCLES(400)
    ) dut (
        .CLOCK_50                      (clk),
        .reset                         (reset),
        .PS2_CLK                       (ps2_clk_w),
        .PS2_DAT                       (ps2_dat_w),
        .command                       (command),
        .send_command                  (send_command),
        .busy                          (busy),
        .command_was_sent              (command_was_sent),
        .error_communication_timed_out (error_communication_timed_out),
        .PS2_CLK_OUT                   (PS2_CLK_OUT),
        .PS2_DAT_OUT                   (PS2_DAT_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Count cycles in which each status pulse is high (width * count).
    always @(negedge clk) begin
        if (command_was_sent === 1'b1) done_seen++;
        if (error_communication_timed_out === 1'b1) begin
            err_seen++;
            err_cyc = cyc;
        end
    end

    // Issue a request, measure the inhibit, then act as the device for up to
    // 11 clock pulses. stop_edge != 0 returns mid-frame with the clock low.
    task automatic run_frame(input logic [7:0] cmd, input logic ack_low,
                             input int stop_edge, input logic inject,
                             output logic [10:0] bits, output int inh_len,
                             output logic started);
        int guard;
        bits    = 11'd0;
        inh_len = 0;
        started = 1'b0;
        @(negedge clk);
        command      = cmd;
        send_command = 1'b1;
        @(negedge clk);
        send_command = 1'b0;
        command      = 8'hA5;           // must not disturb the latched byte
        guard = 0;
        while (PS2_CLK_OUT === 1'b1 && guard < 100) begin
            inh_len++;
            guard++;
            @(negedge clk);
        end
        started = (PS2_DAT_OUT === 1'b1) && (guard < 100);
        if (!started) return;
        rts_cyc = cyc;
        repeat (50) @(negedge clk);
        bits[0] = ps2_dat_w;            // start bit
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) begin
                dev_dat = ack_low ? 1'b0 : 1'b1;
                repeat (5) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (50) @(negedge clk);
            if (k <= 10) bits[k] = ps2_dat_w;
            if (inject && k == 3) begin
                command      = 8'h12;
                send_command = 1'b1;
                @(negedge clk);
                send_command = 1'b0;
            end
            if (k == stop_edge) return;
            repeat (50) @(negedge clk);
            dev_clk = 1'b1;
            if (k == 11) dev_dat = 1'b1;
            repeat (100) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        vec_cnt++;
        if (busy !== 1'b0) begin miscompare_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        vec_cnt++;
        if (PS2_CLK_OUT !== 1'b0) begin miscompare_cnt++; $display("FAIL reset_clk_out: got %b want 0", PS2_CLK_OUT); end
        vec_cnt++;
        if (PS2_DAT_OUT !== 1'b0) begin miscompare_cnt++; $display("FAIL reset_dat_out: got %b want 0", PS2_DAT_OUT); end
        vec_cnt++;
        if (command_was_sent !== 1'b0) begin miscompare_cnt++; $display("FAIL reset_done: got %b want 0", command_was_sent); end
        vec_cnt++;
        if (error_communication_timed_out !== 1'b0) begin miscompare_cnt++; $display("FAIL reset_err: got %b want 0", error_communication_timed_out); end
    endtask

    // 0xED: start 0, d0..d7 = 1,0,1,1,0,1,1,1, parity 1, stop 1 (bit 0 = start).
    task automatic test_send_ed(input logic inject);
        logic [10:0] bits;
        int          inh_len;
        logic        started;
        int          d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        run_frame(8'hED, 1'b1, 0, inject, bits, inh_len, started);
        vec_cnt++;
        if (started !== 1'b1) begin miscompare_cnt++; $display("FAIL ed_rts_reached: got %b want 1", started); end
        vec_cnt++;
        if (bits !== 11'b11_1110_1101_0) begin miscompare_cnt++; $display("FAIL ed_frame_bits (inject=%b): got %b want 11111011010", inject, bits); end
        vec_cnt++;
        if (done_seen - e0 - (done_seen - d0) + (done_seen - d0) - (done_seen - d0) != 0 && 1'b0) begin end
        vec_cnt--;
        vec_cnt++;
        if (done_seen - d0 != 1) begin miscompare_cnt++; $display("FAIL ed_done_pulse_cycles: got %0d want 1", done_seen - d0); end
        vec_cnt++;
        if (err_seen - e0 != 0) begin miscompare_cnt++; $display("FAIL ed_err_pulse_cycles: got %0d want 0", err_seen - e0); end
        vec_cnt++;
        if (busy !== 1'b0) begin miscompare_cnt++; $display("FAIL ed_busy_after: got %b want 0", busy); end
        vec_cnt++;
        if ({PS2_CLK_OUT, PS2_DAT_OUT} !== 2'b00) begin miscompare_cnt++; $display("FAIL ed_lines_released: got %b want 00", {PS2_CLK_OUT, PS2_DAT_OUT}); end
    endtask

    // 0xF4: d0..d7 = 0,0,1,0,1,1,1,1, parity 0; also checks the 8-cycle inhibit.
    task automatic test_send_f4();
        logic [10:0] bits;
        int          inh_len;
        logic        started;
        int          d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        run_frame(8'hF4, 1'b1, 0, 1'b0, bits, inh_len, started);
        vec_cnt++;
        if (started !== 1'b1) begin miscompare_cnt++; $display("FAIL f4_rts_reached: got %b want 1", started); end
        vec_cnt++;
        if (inh_len != 8) begin miscompare_cnt++; $display("FAIL f4_inhibit_len: got %0d want 8", inh_len); end
        vec_cnt++;
        if (bits !== 11'b10_1111_0100_0) begin miscompare_cnt++; $display("FAIL f4_frame_bits: got %b want 10111101000", bits); end
        vec_cnt++;
        if (done_seen - d0 != 1) begin miscompare_cnt++; $display("FAIL f4_done_pulse_cycles: got %0d want 1", done_seen - d0); end
        vec_cnt++;
        if (err_seen - e0 != 0) begin miscompare_cnt++; $display("FAIL f4_err_pulse_cycles: got %0d want 0", err_seen - e0); end
        vec_cnt++;
        if (busy !== 1'b0) begin miscompare_cnt++; $display("FAIL f4_busy_after: got %b want 0", busy); end
    endtask

    // 0x55 with the device leaving data high on edge 11.
    task automatic test_no_ack();
        logic [10:0] bits;
        int          inh_len;
        logic        started;
        int          d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        run_frame(8'h55, 1'b0, 0, 1'b0, bits, inh_len, started);
        vec_cnt++;
        if (bits !== 11'b11_0101_0101_0) begin miscompare_cnt++; $display("FAIL noack_frame_bits: got %b want 11010101010", bits); end
        vec_cnt++;
        if (err_seen - e0 != 1) begin miscompare_cnt++; $display("FAIL noack_err_pulse_cycles: got %0d want 1", err_seen - e0); end
        vec_cnt++;
        if (done_seen - d0 != 0) begin miscompare_cnt++; $display("FAIL noack_done_pulse_cycles: got %0d want 0", done_seen - d0); end
        vec_cnt++;
        if ({PS2_CLK_OUT, PS2_DAT_OUT} !== 2'b00) begin miscompare_cnt++; $display("FAIL noack_lines_released: got %b want 00", {PS2_CLK_OUT, PS2_DAT_OUT}); end
        vec_cnt++;
        if (busy !== 1'b0) begin miscompare_cnt++; $display("FAIL noack_busy_after: got %b want 0", busy); end
    endtask

    // 0xFF with the device clock held high: error 400 cycles after RTS entry.
    task automatic test_timeout();
        int d0, e0, guard;
        d0 = done_seen;
        e0 = err_seen;
        dev_clk = 1'b1;
        @(negedge clk);
        command      = 8'hFF;
        send_command = 1'b1;
        @(negedge clk);
        send_command = 1'b0;
        guard = 0;
        while (PS2_DAT_OUT !== 1'b1 && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        rts_cyc = cyc;
        vec_cnt++;
        if (guard >= 100) begin miscompare_cnt++; $display("FAIL tmo_rts_reached: got no RTS within %0d cycles want RTS", guard); end
        guard = 0;
        while (err_seen == e0 && guard < 600) begin
            guard++;
            @(negedge clk);
        end
        vec_cnt++;
        if (err_seen - e0 != 1) begin miscompare_cnt++; $display("FAIL tmo_err_pulse_cycles: got %0d want 1", err_seen - e0); end
        vec_cnt++;
        if (err_cyc - rts_cyc != 400) begin miscompare_cnt++; $display("FAIL tmo_err_latency: got %0d want 400", err_cyc - rts_cyc); end
        repeat (5) @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0) begin miscompare_cnt++; $display("FAIL tmo_busy_after: got %b want 0", busy); end
        vec_cnt++;
        if (done_seen - d0 != 0) begin miscompare_cnt++; $display("FAIL tmo_done_pulse_cycles: got %0d want 0", done_seen - d0); end
        vec_cnt++;
        if ({PS2_CLK_OUT, PS2_DAT_OUT} !== 2'b00) begin miscompare_cnt++; $display("FAIL tmo_lines_released: got %b want 00", {PS2_CLK_OUT, PS2_DAT_OUT}); end
    endtask

    // Reset in the low phase of edge 5 of an 0xED frame, then a clean 0xF4.
    task automatic test_reset_midframe();
        logic [10:0] bits;
        int          inh_len;
        logic        started;
        int          d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        run_frame(8'hED, 1'b1, 5, 1'b0, bits, inh_len, started);
        vec_cnt++;
        if (busy !== 1'b1) begin miscompare_cnt++; $display("FAIL rst_busy_before: got %b want 1", busy); end
        #2 reset = 1'b1;
        #1;
        vec_cnt++;
        if ({PS2_CLK_OUT, PS2_DAT_OUT} !== 2'b00) begin miscompare_cnt++; $display("FAIL rst_lines_async: got %b want 00", {PS2_CLK_OUT, PS2_DAT_OUT}); end
        vec_cnt++;
        if (busy !== 1'b0) begin miscompare_cnt++; $display("FAIL rst_busy_async: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (20) @(negedge clk);
        vec_cnt++;
        if ((done_seen - d0) + (err_seen - e0) != 0) begin miscompare_cnt++; $display("FAIL rst_no_pulse: got %0d pulse cycles want 0", (done_seen - d0) + (err_seen - e0)); end
        test_send_f4();
    endtask

    initial begin
        vec_cnt        = 0;
        miscompare_cnt = 0;
        cyc            = 0;
        done_seen      = 0;
        err_seen       = 0;
        err_cyc        = 0;
        rts_cyc        = 0;
        reset          = 1'b1;
        command        = 8'h00;
        send_command   = 1'b0;
        dev_clk        = 1'b1;
        dev_dat        = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        repeat (5) @(negedge clk);
        test_send_ed(1'b0);
        test_send_f4();
        test_no_ack();
        test_timeout();
        test_send_ed(1'b1);
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by 2000000 ns want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
